ansi_term_decoder: RTL and testbench

- Terminal-side counterpart of the frame renderer: consumes the byte stream the renderer emits (printable text, UTF-8 glyphs, ANSI CSI sequences) and decodes it into discrete draw commands.
- Tracks cursor position, foreground colour and bold as a terminal would, so that a shadow screen model or checker can reconstruct each frame.
- Sits between the renderer's byte output and a screen model or scoreboard.

---
 rtl/ansi_term_decoder.sv | 254 +++++++++++++++++++++++++
 tb/tb_ansi_term_decoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ansi_term_decoder.sv
// ansi_term_decoder: turns a terminal byte stream (text, UTF-8, ANSI CSI)
// into draw commands while tracking cursor, foreground colour and bold.
module ansi_term_decoder #(
    parameter logic [2:0]  DEF_FG     = 3'd7,
    parameter int unsigned MAX_PARAMS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_type,
    output logic [7:0] cmd_char,
    output logic [7:0] cmd_row,
    output logic [7:0] cmd_col,
    output logic [2:0] cmd_fg,
    output logic       cmd_bold
);

    localparam int unsigned IW = $clog2(MAX_PARAMS + 1);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_CHAR    = 3'd0,
        CMD_GOTO    = 3'd1,
        CMD_CLEAR   = 3'd2,
        CMD_SGR     = 3'd3,
        CMD_NEWLINE = 3'd4,
        CMD_ERR     = 3'd7
    } cmd_t;

    state_t        r_state, w_state_nx;
    logic [7:0]    r_row, r_col, w_row_nx, w_col_nx;
    logic [2:0]    r_fg, w_fg_nx;
    logic          r_bold, w_bold_nx;
    logic [7:0]    r_p [MAX_PARAMS];
    logic [7:0]    w_p_nx [MAX_PARAMS];
    logic [IW-1:0] r_pidx, w_pidx_nx;

    logic          w_accept;
    logic          w_emit;
    cmd_t          w_type;
    logic [7:0]    w_char, w_crow, w_ccol;
    logic [11:0]   w_acc;
    logic [7:0]    w_p0, w_p1;

    logic          r_cmd_valid;
    cmd_t          r_cmd_type;
    logic [7:0]    r_cmd_char, r_cmd_row, r_cmd_col;
    logic [2:0]    r_cmd_fg;
    logic          r_cmd_bold;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign in_ready  = ~r_cmd_valid | cmd_ready;
    assign w_accept  = in_valid & in_ready;

    assign cmd_valid = r_cmd_valid;
    assign cmd_type  = r_cmd_type;
    assign cmd_char  = r_cmd_char;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign cmd_fg    = r_cmd_fg;
    assign cmd_bold  = r_cmd_bold;

    // Parser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_GROUND;
        else        r_state <= w_state_nx;
    end

    // Next-state, terminal-state update and command decode for the accepted byte
    always_comb begin
        w_state_nx = r_state;
        w_row_nx   = r_row;
        w_col_nx   = r_col;
        w_fg_nx    = r_fg;
        w_bold_nx  = r_bold;
        w_pidx_nx  = r_pidx;
        for (int unsigned i = 0; i < MAX_PARAMS; i++) w_p_nx[i] = r_p[i];
        w_emit = 1'b0;
        w_type = CMD_CHAR;
        w_char = '0;
        w_crow = r_row;
        w_ccol = r_col;
        w_acc  = '0;
        w_p0   = '0;
        w_p1   = '0;
        for (int unsigned i = 0; i < MAX_PARAMS; i++) begin
            if (i == 0) w_p0 = r_p[i];
            if (i == 1) w_p1 = r_p[i];
        end

        if (w_accept) begin
            unique case (r_state)
                ST_GROUND: begin
                    if (in_byte == 8'h1B) begin
                        w_state_nx = ST_ESC;
                    end else if (in_byte == 8'h0A) begin
                        w_row_nx = sat_inc(r_row);
                        w_col_nx = 8'd1;
                        w_emit   = 1'b1;
                        w_type   = CMD_NEWLINE;
                        w_crow   = w_row_nx;
                        w_ccol   = 8'd1;
                    end else if (in_byte == 8'h0D) begin
                        w_col_nx = 8'd1;
                    end else if (in_byte < 8'h20 || in_byte == 8'h7F) begin
                        w_emit = 1'b0;
                    end else if (in_byte[7:6] == 2'b10) begin
                        // continuation byte belongs to the glyph just placed
                        w_emit = 1'b1;
                        w_type = CMD_CHAR;
                        w_char = in_byte;
                        w_ccol = (r_col > 8'd1) ? r_col - 8'd1 : 8'd1;
                    end else begin
                        w_emit   = 1'b1;
                        w_type   = CMD_CHAR;
                        w_char   = in_byte;
                        w_col_nx = sat_inc(r_col);
                    end
                end
                ST_ESC: begin
                    if (in_byte == 8'h5B) begin
                        for (int unsigned i = 0; i < MAX_PARAMS; i++) w_p_nx[i] = '0;
                        w_pidx_nx  = '0;
                        w_state_nx = ST_CSI;
                    end else begin
                        w_emit     = 1'b1;
                        w_type     = CMD_ERR;
                        w_char     = in_byte;
                        w_state_nx = ST_GROUND;
                    end
                end
                ST_CSI: begin
                    if (in_byte >= 8'h30 && in_byte <= 8'h39) begin
                        // indices past MAX_PARAMS match no slot and are dropped
                        for (int unsigned i = 0; i < MAX_PARAMS; i++) begin
                            if (i == 32'(r_pidx)) begin
                                w_acc     = 12'(r_p[i]) * 12'd10 + 12'(in_byte[3:0]);
                                w_p_nx[i] = (w_acc > 12'd255) ? 8'hFF : w_acc[7:0];
                            end
                        end
                    end else if (in_byte == 8'h3B) begin
                        if (32'(r_pidx) < MAX_PARAMS) w_pidx_nx = r_pidx + IW'(1);
                    end else if (in_byte == 8'h1B) begin
                        w_emit     = 1'b1;
                        w_type     = CMD_ERR;
                        w_char     = in_byte;
                        w_state_nx = ST_ESC;
                    end else if (in_byte >= 8'h40 && in_byte <= 8'h7E) begin
                        w_state_nx = ST_GROUND;
                        w_emit     = 1'b1;
                        case (in_byte)
                            8'h48: begin
                                w_row_nx = (w_p0 == 8'd0) ? 8'd1 : w_p0;
                                w_col_nx = (w_p1 == 8'd0) ? 8'd1 : w_p1;
                                w_type   = CMD_GOTO;
                                w_crow   = w_row_nx;
                                w_ccol   = w_col_nx;
                            end
                            8'h4A: begin
                                if (w_p0 == 8'd2) begin
                                    w_type = CMD_CLEAR;
                                end else begin
                                    w_type = CMD_ERR;
                                    w_char = in_byte;
                                end
                            end
                            8'h6D: begin
                                // apply each received parameter in order
                                for (int unsigned i = 0; i < MAX_PARAMS; i++) begin
                                    if (i <= 32'(r_pidx)) begin
                                        if (r_p[i] == 8'd0) begin
                                            w_fg_nx   = DEF_FG;
                                            w_bold_nx = 1'b0;
                                        end else if (r_p[i] == 8'd1) begin
                                            w_bold_nx = 1'b1;
                                        end else if (r_p[i] >= 8'd30 && r_p[i] <= 8'd37) begin
                                            w_fg_nx = 3'(r_p[i] - 8'd30);
                                        end
                                    end
                                end
                                w_type = CMD_SGR;
                            end
                            default: begin
                                w_type = CMD_ERR;
                                w_char = in_byte;
                            end
                        endcase
                    end else begin
                        w_emit     = 1'b1;
                        w_type     = CMD_ERR;
                        w_char     = in_byte;
                        w_state_nx = ST_GROUND;
                    end
                end
                default: w_state_nx = ST_GROUND;
            endcase
        end
    end

    // Cursor, attribute and CSI parameter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= 8'd1;
            r_col  <= 8'd1;
            r_fg   <= DEF_FG;
            r_bold <= 1'b0;
            r_pidx <= '0;
            for (int unsigned i = 0; i < MAX_PARAMS; i++) r_p[i] <= '0;
        end else begin
            r_row  <= w_row_nx;
            r_col  <= w_col_nx;
            r_fg   <= w_fg_nx;
            r_bold <= w_bold_nx;
            r_pidx <= w_pidx_nx;
            for (int unsigned i = 0; i < MAX_PARAMS; i++) r_p[i] <= w_p_nx[i];
        end
    end

    // Single command output register with valid/ready hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= CMD_CHAR;
            r_cmd_char  <= '0;
            r_cmd_row   <= 8'd1;
            r_cmd_col   <= 8'd1;
            r_cmd_fg    <= DEF_FG;
            r_cmd_bold  <= 1'b0;
        end else if (w_accept && w_emit) begin
            r_cmd_valid <= 1'b1;
            r_cmd_type  <= w_type;
            r_cmd_char  <= w_char;
            r_cmd_row   <= w_crow;
            r_cmd_col   <= w_ccol;
            r_cmd_fg    <= w_fg_nx;
            r_cmd_bold  <= w_bold_nx;
        end else if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ansi_term_decoder.sv
// tb_ansi_term_decoder: directed and random byte streams checked against a
// behavioural terminal model.
module tb_ansi_term_decoder;

    localparam int MAXP = 2;
    localparam int DEFC = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [2:0] cmd_type;
    logic [7:0] cmd_char;
    logic [7:0] cmd_row;
    logic [7:0] cmd_col;
    logic [2:0] cmd_fg;
    logic       cmd_bold;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;            // 0 never ready, 1 always ready, 2 random

    ansi_term_decoder #(.DEF_FG(3'd7), .MAX_PARAMS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_char(cmd_char), .cmd_row(cmd_row),
        .cmd_col(cmd_col), .cmd_fg(cmd_fg), .cmd_bold(cmd_bold)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int t, input int c, input int r, input int co,
                                       input int f, input int b);
        return {1'b0, 3'(t), 8'(c), 8'(r), 8'(co), 3'(f), 1'(b)};
    endfunction

    function automatic logic [31:0] obs_now();
        return {1'b0, cmd_type, cmd_char, cmd_row, cmd_col, cmd_fg, cmd_bold};
    endfunction

    // ---------------- reference terminal model ----------------
    int          m_mode;         // 0 text, 1 after ESC, 2 inside CSI
    int          m_row, m_col, m_fg, m_bold;
    logic [7:0]  m_seq[$];       // raw parameter characters of the CSI
    logic [31:0] exp_q[$];
    logic [31:0] last_obs;

    function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

    task automatic m_reset();
        m_mode = 0; m_row = 1; m_col = 1; m_fg = DEFC; m_bold = 0;
        m_seq.delete();
        exp_q.delete();
    endtask

    task automatic m_push(input int t, input int c, input int r, input int co);
        exp_q.push_back(pk(t, c, r, co, m_fg, m_bold));
    endtask

    task automatic m_exec(input int fin);
        int vals[$];
        int cur = 0;
        int p0, p1;
        foreach (m_seq[k]) begin
            if (m_seq[k] == 8'h3B) begin vals.push_back(cur); cur = 0; end
            else cur = imin(cur * 10 + int'(m_seq[k]) - 48, 255);
        end
        vals.push_back(cur);
        while (vals.size() > MAXP) void'(vals.pop_back());
        p0 = vals[0];
        p1 = (vals.size() > 1) ? vals[1] : 0;
        if (fin == 8'h48) begin
            m_row = imax(p0, 1); m_col = imax(p1, 1);
            m_push(1, 0, m_row, m_col);
        end else if (fin == 8'h4A) begin
            if (p0 == 2) m_push(2, 0, m_row, m_col);
            else         m_push(7, fin, m_row, m_col);
        end else if (fin == 8'h6D) begin
            foreach (vals[k]) begin
                if (vals[k] == 0) begin m_fg = DEFC; m_bold = 0; end
                else if (vals[k] == 1) m_bold = 1;
                else if (vals[k] >= 30 && vals[k] <= 37) m_fg = vals[k] - 30;
            end
            m_push(3, 0, m_row, m_col);
        end else begin
            m_push(7, fin, m_row, m_col);
        end
    endtask

    task automatic m_byte(input logic [7:0] bb);
        int b = int'(bb);
        if (m_mode == 0) begin
            if (b == 27) m_mode = 1;
            else if (b == 10) begin m_row = imin(m_row + 1, 255); m_col = 1; m_push(4, 0, m_row, 1); end
            else if (b == 13) m_col = 1;
            else if (b < 32 || b == 127) begin end
            else if (b >= 128 && b <= 191) m_push(0, b, m_row, imax(m_col - 1, 1));
            else begin m_push(0, b, m_row, m_col); m_col = imin(m_col + 1, 255); end
        end else if (m_mode == 1) begin
            if (b == 91) begin m_seq.delete(); m_mode = 2; end
            else begin m_push(7, b, m_row, m_col); m_mode = 0; end
        end else begin
            if ((b >= 48 && b <= 57) || b == 59) m_seq.push_back(bb);
            else if (b == 27) begin m_push(7, 27, m_row, m_col); m_mode = 1; end
            else if (b >= 64 && b <= 126) begin m_exec(b); m_mode = 0; end
            else begin m_push(7, b, m_row, m_col); m_mode = 0; end
        end
    endtask

    // ---------------- drivers and monitor ----------------
    initial forever begin
        @(negedge clk);
        if (rdy_mode == 0)      cmd_ready = 1'b0;
        else if (rdy_mode == 1) cmd_ready = 1'b1;
        else                    cmd_ready = ($urandom_range(0, 99) < 70);
    end

    initial begin : monitor
        logic        held;
        logic [31:0] snap;
        held = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) check_eq("hold_stable", obs_now(), snap);
                if (cmd_valid && cmd_ready) begin
                    last_obs = obs_now();
                    if (exp_q.size() == 0) check_eq("unexpected_cmd", obs_now(), 32'hFFFF_FFFF);
                    else check_eq("cmd", obs_now(), exp_q.pop_front());
                    held = 1'b0;
                end else if (cmd_valid) begin
                    held = 1'b1;
                    snap = obs_now();
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        #1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", 32'(waited), 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            m_byte(b);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_csi(input string s);
        send_byte(8'h1B);
        send_str({"[", s});
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 1;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_token();
        int n;
        string s;
        case ($urandom_range(0, 9))
            0, 1: send_byte(8'($urandom_range(32, 126)));
            2: begin
                send_byte(8'hE2);
                send_byte(8'($urandom_range(128, 191)));
                send_byte(8'($urandom_range(128, 191)));
            end
            3: begin
                n = $urandom_range(0, 3);
                if (n == 0) send_byte(8'h0A);
                else if (n == 1) send_byte(8'h0D);
                else if (n == 2) send_byte(8'h7F);
                else send_byte(8'($urandom_range(0, 26)));
            end
            4: begin
                s = ($urandom_range(0, 3) == 0) ? "" : $sformatf("%0d", $urandom_range(0, 300));
                if ($urandom_range(0, 1) == 1) s = {s, ";", $sformatf("%0d", $urandom_range(0, 300))};
                send_csi({s, "H"});
            end
            5: begin
                s = "";
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    if (k > 0) s = {s, ";"};
                    case ($urandom_range(0, 3))
                        0: s = {s, "0"};
                        1: s = {s, "1"};
                        2: s = {s, $sformatf("%0d", $urandom_range(30, 37))};
                        default: s = {s, $sformatf("%0d", $urandom_range(0, 99))};
                    endcase
                end
                send_csi({s, "m"});
            end
            6: send_csi({$sformatf("%0d", $urandom_range(0, 3)), "J"});
            7: begin
                send_byte(8'h1B);
                n = $urandom_range(0, 255);
                send_byte((n == 91) ? 8'h51 : 8'(n));
            end
            8: begin
                send_csi($sformatf("%0d", $urandom_range(0, 50)));
                send_byte(8'($urandom_range(0, 255)));
            end
            default: begin
                send_csi("253;254H");
                repeat (4) send_byte(8'h0A);
                repeat (3) send_byte(8'h41);
            end
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_byte = '0;
        m_reset();
        last_obs = '0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_outs", obs_now(), pk(0, 0, 1, 1, 7, 0));
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // "AB": one-cycle latency, glyph positions 1,1 and 1,2
        send_byte(8'h41);
        @(negedge clk); #2;
        check_eq("lat_A", {23'd0, cmd_valid, cmd_char}, {23'd0, 1'b1, 8'h41});
        send_byte(8'h42);
        @(negedge clk); #2;
        check_eq("lat_B", {15'd0, cmd_valid, cmd_char, cmd_col}, {15'd0, 1'b1, 8'h42, 8'd2});
        drain();
        send_byte(8'h43);
        drain();
        check_eq("col_after_AB", last_obs, pk(0, 8'h43, 1, 3, 7, 0));

        send_csi("12;34H"); drain();
        check_eq("goto_12_34", last_obs, pk(1, 0, 12, 34, 7, 0));
        send_byte(8'h78); drain();
        check_eq("char_x", last_obs, pk(0, 8'h78, 12, 34, 7, 0));
        send_csi("H"); drain();
        check_eq("goto_home", last_obs, pk(1, 0, 1, 1, 7, 0));

        send_csi("1;32m"); drain();
        check_eq("sgr_bold_green", last_obs, pk(3, 0, 1, 1, 2, 1));
        send_csi("0m"); drain();
        check_eq("sgr_reset", last_obs, pk(3, 0, 1, 1, 7, 0));
        send_csi("2J"); drain();
        check_eq("clear", last_obs, pk(2, 0, 1, 1, 7, 0));

        send_csi("3;5H");
        send_byte(8'hE2); send_byte(8'h96); send_byte(8'h88); drain();
        check_eq("utf8_last", last_obs, pk(0, 8'h88, 3, 5, 7, 0));
        send_byte(8'h79); drain();
        check_eq("utf8_advance", last_obs, pk(0, 8'h79, 3, 6, 7, 0));

        // backpressure: 'A' held four cycles, 'B' waits
        rdy_mode = 0;
        @(negedge clk); @(negedge clk);
        send_byte(8'h41);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = 8'h42;
        for (int k = 0; k < 4; k++) begin
            #2;
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_hold_A", {23'd0, cmd_valid, cmd_char}, {23'd0, 1'b1, 8'h41});
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        send_byte(8'h42);
        drain();
        check_eq("stall_B_after", last_obs, pk(0, 8'h42, 3, 8, 7, 0));

        send_csi("999;7H"); drain();
        check_eq("goto_sat", last_obs, pk(1, 0, 255, 7, 7, 0));
        send_byte(8'h0A); drain();
        check_eq("newline_sat", last_obs, pk(4, 0, 255, 1, 7, 0));
        send_byte(8'h1B); send_byte(8'h51); drain();
        check_eq("esc_err", last_obs, pk(7, 8'h51, 255, 1, 7, 0));
        send_csi("5K"); drain();
        check_eq("bad_final", last_obs, pk(7, 8'h4B, 255, 1, 7, 0));

        // reset in the middle of a CSI
        send_byte(8'h1B); send_byte(8'h5B); send_byte(8'h33);
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #2;
        check_eq("midrst_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h35); send_byte(8'h6D); drain();
        check_eq("midrst_chars", last_obs, pk(0, 8'h6D, 1, 2, 7, 0));

        // random traffic with random backpressure
        for (int t = 0; t < 400; t++) begin
            rdy_mode = 2;
            rand_token();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
